registrador_historico: RTL and testbench
========================================

REGISTRADOR_HISTORICO -- requirements
Module: registrador_historico

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bits per stored word.
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of history entries (legal range 2..64).
REQ-003 SHALL have port CLK  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port LOAD  input  1  pushes `a` as the newest entry on this edge.
REQ-006 SHALL have port CLEAR  input  1  synchronous flush of all entries.
REQ-007 SHALL have port a  input  WIDTH  data word to store.
REQ-008 SHALL have port rd_idx  input  clog2(DEPTH)  read index, 0 = newest.
REQ-009 SHALL have port s  output  WIDTH  registered newest entry (entry 0).
REQ-010 SHALL have port rd_data  output  WIDTH  combinational read of entry rd_idx.
REQ-011 SHALL have port count  output  clog2(DEPTH+1)  number of valid entries.
REQ-012 SHALL have ports full and empty  output  1 each  count==DEPTH and count==0.
REQ-013 SHALL have port drop  output  1  one-cycle pulse when the oldest entry is discarded.

Function
REQ-014 On LOAD=1, CLEAR=0 the block SHALL shift entry i to entry i+1 for all i and write `a` to entry 0 on the same edge; s shows the new word one edge after LOAD.
REQ-015 count SHALL increment by 1 on LOAD when count<DEPTH and hold at DEPTH when full.
REQ-016 LOAD while full SHALL discard entry DEPTH-1 and assert drop for exactly the following cycle; drop SHALL be 0 otherwise.
REQ-017 CLEAR=1 SHALL zero all entries, count, and drop on the next edge, and SHALL take priority over a simultaneous LOAD (the word is not stored).
REQ-018 LOAD=0, CLEAR=0 SHALL hold all state; drop returns to 0.
REQ-019 rd_data SHALL equal entry rd_idx when rd_idx<count, else all zeros (invalid or out-of-range index, including rd_idx>=DEPTH for non-power-of-two DEPTH).
REQ-020 Back-to-back LOAD on every cycle SHALL store every word with no bubble.

Reset
REQ-021 RESET=1 SHALL immediately, independent of CLK, force all entries, s, count, and drop to 0, and empty to 1, full to 0.
REQ-022 RESET asserted mid-operation SHALL discard the whole history; the first edge after release with LOAD=1 stores into entry 0 with count becoming 1.

Configuration
REQ-023 Macro REGISTRADOR_HISTORICO_PARIDADE_EN, when defined, SHALL add output rd_par (1 bit) and a parity bit per entry computed as XOR of `a` at load time, shifting with its word; rd_par SHALL be 0 for invalid indices and cleared by RESET/CLEAR.
REQ-024 Without REGISTRADOR_HISTORICO_PARIDADE_EN the rd_par port and parity storage SHALL be absent and all other behaviour identical.

Structure
REQ-025 A shared package SHALL hold the default WIDTH/DEPTH constants and the index/count width function (clog2) used by this block and its bench.
REQ-026 Each history entry SHALL be an instance of sub-module registrador_entrada (WIDTH-bit register with async RESET, sync CLEAR, enable), generated DEPTH times; count/drop control stays in the top.

Verification (bench with WIDTH=4, DEPTH=4)
REQ-027 RESET pulse mid-cycle with CLK stopped -> s=0000, count=0, empty=1, full=0, drop=0 immediately.
REQ-028 LOAD a=0001,0010,0011 on three edges -> count=3, rd_idx 0/1/2 -> 0011/0010/0001, rd_idx=3 -> 0000.
REQ-029 Continue LOAD 0100 then 0101 -> after 0100 full=1, drop=0; after 0101 drop=1 for one cycle, entries 0101,0100,0011,0010, count stays 4.
REQ-030 LOAD=1 and CLEAR=1 on same edge with a=1111 -> count=0, s=0000, empty=1, no 1111 stored.
REQ-031 With macro defined, LOAD a=0111 then 0011 -> rd_par at idx0=0, idx1=1; after CLEAR rd_par=0.
REQ-032 Assert RESET asynchronously between LOADs at count=2 -> count=0 immediately; next LOAD a=1010 -> count=1, s=1010.

Source files
------------

// File: rtl/registrador_historico_pkg.sv
// registrador_historico_pkg
// Shared constants and helpers for the history register block and its bench.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and history depth
//   clog2()                       : index/count width helper (minimum 1 bit)
// Optional feature macro used by this block: REGISTRADOR_HISTORICO_PARIDADE_EN
package registrador_historico_pkg;

  localparam int DEFAULT_WIDTH = 32'd4;
  localparam int DEFAULT_DEPTH = 32'd8;

  // Ceiling log2, never less than one bit so a port width is always legal.
  function automatic int clog2(input int value);
    int r;
    r = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    if (r == 32'd0) begin
      r = 32'd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/registrador_historico_if.sv
// registrador_historico_if
// Bundles the load/clear/read bus of the history register.
//   LOAD, CLEAR, a, rd_idx             : driven by the master
//   s, rd_data, count, full, empty,
//   drop (and rd_par when
//   REGISTRADOR_HISTORICO_PARIDADE_EN) : driven by the history register
interface registrador_historico_if
  import registrador_historico_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int IW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic             LOAD;
  logic             CLEAR;
  logic [WIDTH-1:0] a;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             drop;
`ifdef REGISTRADOR_HISTORICO_PARIDADE_EN
  logic             rd_par;
`endif

  modport master (
    output LOAD, CLEAR, a, rd_idx,
`ifdef REGISTRADOR_HISTORICO_PARIDADE_EN
    input  rd_par,
`endif
    input  s, rd_data, count, full, empty, drop
  );

  modport slave (
    input  LOAD, CLEAR, a, rd_idx,
`ifdef REGISTRADOR_HISTORICO_PARIDADE_EN
    output rd_par,
`endif
    output s, rd_data, count, full, empty, drop
  );

endinterface

// File: rtl/registrador_historico_entrada.sv
// registrador_entrada
// One history slot: WIDTH-bit register.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset (clears q)
//   clear : synchronous clear, wins over en
//   en    : load d on the next edge
//   d / q : data in / stored word
module registrador_entrada #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Slot storage: async reset, then sync clear, then enabled load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/registrador_historico.sv
// registrador_historico
// Shift-style history of the last DEPTH words pushed with LOAD; entry 0 is
// the newest. Optional per-entry parity with REGISTRADOR_HISTORICO_PARIDADE_EN.
//   CLK    : rising-edge clock
//   RESET  : asynchronous active-high reset
//   bus    : slave side of registrador_historico_if
//            (LOAD, CLEAR, a, rd_idx in; s, rd_data, count, full, empty,
//             drop, optional rd_par out)
module registrador_historico
  import registrador_historico_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic                  CLK,
  input logic                  RESET,
  registrador_historico_if.slave bus
);

  localparam int IW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

`ifdef REGISTRADOR_HISTORICO_PARIDADE_EN
  // Stored word carries its parity bit in the MSB so it shifts with the data.
  localparam int EW = WIDTH + 1;

  function automatic logic parity_of(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`else
  localparam int EW = WIDTH;
`endif

  logic [EW-1:0] word_in_s;
  logic [EW-1:0] entry_d_s [DEPTH];
  logic [EW-1:0] entry_q_s [DEPTH];
  logic          shift_en_s;
  logic [EW-1:0] rd_word_s;
  logic [CW-1:0] count_r;
  logic          drop_r;

`ifdef REGISTRADOR_HISTORICO_PARIDADE_EN
  assign word_in_s = {parity_of(bus.a), bus.a};
`else
  assign word_in_s = bus.a;
`endif

  // CLEAR also gates the shift so a simultaneous LOAD is not stored.
  assign shift_en_s = bus.LOAD & ~bus.CLEAR;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    if (g == 0) begin : g_head
      assign entry_d_s[g] = word_in_s;
    end else begin : g_tail
      assign entry_d_s[g] = entry_q_s[g-1];
    end

    registrador_entrada #(
      .WIDTH (EW)
    ) u_entrada (
      .clk   (CLK),
      .rst   (RESET),
      .clear (bus.CLEAR),
      .en    (shift_en_s),
      .d     (entry_d_s[g]),
      .q     (entry_q_s[g])
    );
  end

  // Occupancy counter and discard pulse; saturates at DEPTH.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_r <= '0;
      drop_r  <= 1'b0;
    end else if (bus.CLEAR) begin
      count_r <= '0;
      drop_r  <= 1'b0;
    end else if (bus.LOAD) begin
      if (count_r == CW'(DEPTH)) begin
        count_r <= count_r;
        drop_r  <= 1'b1;
      end else begin
        count_r <= count_r + CW'(1);
        drop_r  <= 1'b0;
      end
    end else begin
      count_r <= count_r;
      drop_r  <= 1'b0;
    end
  end

  // Read mux: only indices below count (hence below DEPTH) return data.
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((IW'(i) == bus.rd_idx) && (CW'(i) < count_r)) begin
        rd_word_s = entry_q_s[i];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  assign bus.s       = entry_q_s[0][WIDTH-1:0];
  assign bus.rd_data = rd_word_s[WIDTH-1:0];
  assign bus.count   = count_r;
  assign bus.full    = (count_r == CW'(DEPTH));
  assign bus.empty   = (count_r == CW'(0));
  assign bus.drop    = drop_r;
`ifdef REGISTRADOR_HISTORICO_PARIDADE_EN
  assign bus.rd_par  = rd_word_s[EW-1];
`endif

endmodule

// File: tb/tb_registrador_historico.sv
// tb_registrador_historico
// Directed self-checking bench for registrador_historico with WIDTH=4, DEPTH=4.
// Parity checks are compiled in with REGISTRADOR_HISTORICO_PARIDADE_EN.
module tb_registrador_historico;
  import registrador_historico_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  logic clk;
  logic rst;
  logic clk_run;
  int   checks;
  int   errors;

  registrador_historico_if #(.WIDTH(W), .DEPTH(D)) bus ();

  registrador_historico #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Gated clock so the reset test can stop it.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.LOAD = 1'b0; bus.CLEAR = 1'b0; bus.a = 4'h0; bus.rd_idx = 2'd0;
    #12 rst = 1'b0;
    bus.LOAD = 1'b1; bus.a = 4'h9;
    tick();
    bus.LOAD = 1'b0;
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL pre_reset_count got %0d expected 1", bus.count); end
    clk_run = 1'b0;
    #4 rst = 1'b1;
    #1;
    checks++; if (bus.s !== 4'h0) begin errors++; $display("FAIL reset_s got %h expected 0", bus.s); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", bus.full); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b expected 0", bus.drop); end
    #2 rst = 1'b0;
    clk_run = 1'b1;
  endtask

  task automatic test_load();
    logic [3:0] exp_rd [4];
    exp_rd[0] = 4'h3; exp_rd[1] = 4'h2; exp_rd[2] = 4'h1; exp_rd[3] = 4'h0;
    for (int i = 1; i <= 3; i++) begin
      bus.LOAD = 1'b1; bus.a = 4'(i);
      tick();
    end
    bus.LOAD = 1'b0;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL load_count got %0d expected 3", bus.count); end
    checks++; if (bus.s !== 4'h3) begin errors++; $display("FAIL load_s got %h expected 3", bus.s); end
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 2'(i);
      #1;
      checks++; if (bus.rd_data !== exp_rd[i]) begin errors++; $display("FAIL load_rd%0d got %h expected %h", i, bus.rd_data, exp_rd[i]); end
    end
  endtask

  task automatic test_full_drop();
    logic [3:0] exp_rd [4];
    exp_rd[0] = 4'h5; exp_rd[1] = 4'h4; exp_rd[2] = 4'h3; exp_rd[3] = 4'h2;
    bus.LOAD = 1'b1; bus.a = 4'h4;
    tick();
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_set got %b expected 1", bus.full); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL full_nodrop got %b expected 0", bus.drop); end
    bus.a = 4'h5;
    tick();
    bus.LOAD = 1'b0;
    checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b expected 1", bus.drop); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d expected 4", bus.count); end
    tick();
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL drop_release got %b expected 0", bus.drop); end
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 2'(i);
      #1;
      checks++; if (bus.rd_data !== exp_rd[i]) begin errors++; $display("FAIL full_rd%0d got %h expected %h", i, bus.rd_data, exp_rd[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rd [4];
    exp_rd[0] = 4'h7; exp_rd[1] = 4'h6; exp_rd[2] = 4'h5; exp_rd[3] = 4'h4;
    bus.LOAD = 1'b1; bus.a = 4'h6;
    tick();
    bus.a = 4'h7;
    tick();
    // LOAD stays high so the next task exercises LOAD+CLEAR while drop is set.
    checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL b2b_drop got %b expected 1", bus.drop); end
    checks++; if (bus.s !== 4'h7) begin errors++; $display("FAIL b2b_s got %h expected 7", bus.s); end
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 2'(i);
      #1;
      checks++; if (bus.rd_data !== exp_rd[i]) begin errors++; $display("FAIL b2b_rd%0d got %h expected %h", i, bus.rd_data, exp_rd[i]); end
    end
  endtask

  task automatic test_clear_priority();
    bus.LOAD = 1'b1; bus.CLEAR = 1'b1; bus.a = 4'hF; bus.rd_idx = 2'd0;
    tick();
    bus.LOAD = 1'b0; bus.CLEAR = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d expected 0", bus.count); end
    checks++; if (bus.s !== 4'h0) begin errors++; $display("FAIL clr_s got %h expected 0", bus.s); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL clr_empty got %b expected 1", bus.empty); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL clr_drop got %b expected 0", bus.drop); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL clr_full got %b expected 0", bus.full); end
    checks++; if (bus.rd_data !== 4'h0) begin errors++; $display("FAIL clr_rd0 got %h expected 0", bus.rd_data); end
  endtask

  task automatic test_reset_mid();
    bus.LOAD = 1'b1; bus.a = 4'h1;
    tick();
    bus.a = 4'h2;
    tick();
    bus.LOAD = 1'b0;
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL mid_pre_count got %0d expected 2", bus.count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d expected 0", bus.count); end
    checks++; if (bus.s !== 4'h0) begin errors++; $display("FAIL mid_s got %h expected 0", bus.s); end
    #1 rst = 1'b0;
    bus.LOAD = 1'b1; bus.a = 4'hA;
    tick();
    bus.LOAD = 1'b0;
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL mid_load_count got %0d expected 1", bus.count); end
    checks++; if (bus.s !== 4'hA) begin errors++; $display("FAIL mid_load_s got %h expected a", bus.s); end
    bus.rd_idx = 2'd1;
    #1;
    checks++; if (bus.rd_data !== 4'h0) begin errors++; $display("FAIL mid_rd1 got %h expected 0", bus.rd_data); end
  endtask

`ifdef REGISTRADOR_HISTORICO_PARIDADE_EN
  task automatic test_parity();
    bus.LOAD = 1'b1; bus.a = 4'h7;
    tick();
    bus.a = 4'h3;
    tick();
    bus.LOAD = 1'b0;
    bus.rd_idx = 2'd0;
    #1;
    checks++; if (bus.rd_par !== 1'b0) begin errors++; $display("FAIL par_idx0 got %b expected 0", bus.rd_par); end
    bus.rd_idx = 2'd1;
    #1;
    checks++; if (bus.rd_par !== 1'b1) begin errors++; $display("FAIL par_idx1 got %b expected 1", bus.rd_par); end
    bus.rd_idx = 2'd3;
    #1;
    checks++; if (bus.rd_par !== 1'b0) begin errors++; $display("FAIL par_invalid got %b expected 0", bus.rd_par); end
    bus.CLEAR = 1'b1;
    tick();
    bus.CLEAR = 1'b0;
    bus.rd_idx = 2'd1;
    #1;
    checks++; if (bus.rd_par !== 1'b0) begin errors++; $display("FAIL par_clear got %b expected 0", bus.rd_par); end
  endtask
`endif

  initial begin
    clk = 1'b0;
    clk_run = 1'b1;
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_full_drop();
    test_back_to_back();
    test_clear_priority();
    test_reset_mid();
`ifdef REGISTRADOR_HISTORICO_PARIDADE_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
